latch_regfile_dump: RTL and testbench
=====================================

Name: latch_regfile_dump

Overview:
- Parametrised successor to the board's fixed 4x4 latch register test array.
- NREGS x XLEN register file: one write port, two read ports, optional hardwired-zero register 0, optional write-through bypass.
- A dump sequencer streams every register out over a valid/ready port for board-level readback.
- Sits between the pin-header test harness and the register storage; single clock domain.

Parameters:
XLEN, 4, data width in bits (1..32)
NREGS, 4, number of registers (power of two, 2..32)
AW, log2(NREGS), address width (derived, not overridable)
ZERO_REG, 0, 1 = register 0 reads 0 and ignores writes
BYPASS, 0, 1 = same-cycle write data forwarded to read ports

Ports:
CLK  input  1  clock, all state updates on rising edge
nRST  input  1  synchronous active-low reset
WE  input  1  write enable
WADDR  input  AW  write address
WDATA  input  XLEN  write data
RADDR1  input  AW  read port 1 address
RDATA1  output  XLEN  read port 1 data (combinational)
RADDR2  input  AW  read port 2 address
RDATA2  output  XLEN  read port 2 data (combinational)
DUMP_START  input  1  pulse: begin dump of all registers
DUMP_BUSY  output  1  dump sequence in progress
DUMP_VALID  output  1  DUMP_ADDR/DUMP_DATA valid
DUMP_READY  input  1  consumer accepts current word
DUMP_ADDR  output  AW  address of dumped word
DUMP_DATA  output  XLEN  dumped word

Behaviour:
- Reset: synchronous, sampled on the CLK rising edge while nRST=0. All registers := 0; FSM := IDLE; DUMP_BUSY=0, DUMP_VALID=0, DUMP_ADDR=0, DUMP_DATA=0. Reset overrides WE and DUMP_START in the same cycle. Reset mid-dump aborts the dump with no further words.
- Write: on the rising edge with WE=1 and nRST=1, reg[WADDR] := WDATA. If ZERO_REG=1 and WADDR=0, the write is discarded.
- Read: RDATAn = reg[RADDRn], or 0 if ZERO_REG=1 and RADDRn=0.
- Bypass, BYPASS=1: if WE=1 and WADDR=RADDRn (not a discarded zero-register write), RDATAn = WDATA in the same cycle.
- Bypass, BYPASS=0: new data is visible the cycle after the write edge.
- Simultaneous RADDR1=RADDR2 is legal; both ports return identical data.
- Dump FSM states: IDLE, LOAD, SEND.
- IDLE: DUMP_BUSY=0, DUMP_VALID=0. DUMP_START=1 -> LOAD, with ptr := 0.
- LOAD (one cycle): capture DUMP_DATA := read(ptr), applying ZERO_REG but not the bypass, and DUMP_ADDR := ptr -> SEND. DUMP_BUSY=1, DUMP_VALID=0.
- SEND: DUMP_VALID=1; DUMP_ADDR and DUMP_DATA are held stable until the handshake.
- Handshake: transfer occurs on a rising edge with DUMP_VALID=1 and DUMP_READY=1.
  - If ptr=NREGS-1: -> IDLE, DUMP_VALID:=0, DUMP_BUSY:=0.
  - Else: ptr := ptr+1 -> LOAD.
- Throughput: one word per 2 cycles, minimum. Total dump with READY held high = 2*NREGS cycles from the START edge to the BUSY fall.
- DUMP_START while DUMP_BUSY=1 is ignored.
- Writes during a dump are allowed. A word already captured (SEND) keeps its old value; later words reflect writes committed before their LOAD edge.
- DUMP_READY=1 outside SEND has no effect.
- ptr does not wrap past NREGS-1.

Test Plan:
- Reset/write/read: nRST=0 one cycle, then write reg1=0xA and reg3=0x5 with defaults -> RDATA1(RADDR1=1)=0xA, RDATA2(RADDR2=3)=0x5; reg0 and reg2 read 0.
- ZERO_REG=1, XLEN=8, NREGS=8: write reg0=0xFF -> RADDR1=0 reads 0x00. BYPASS=1: WE, WADDR=5, WDATA=0x3C with RADDR2=5 in the same cycle -> RDATA2=0x3C before the edge. BYPASS=0: old value before the edge, 0x3C after.
- Full dump, defaults, regs=0x1,0x2,0x3,0x4, READY=1: DUMP_START pulse -> VALID words (0,0x1),(1,0x2),(2,0x3),(3,0x4) on alternate cycles; BUSY falls 8 cycles after the START edge.
- Backpressure: READY=0 for 5 cycles during word 2 -> ADDR=2, DATA=0x3 held stable with VALID=1; resumes on READY=1 with no word lost or duplicated.
- Write during dump: while SEND on addr 1, write reg1=0xF and reg3=0x9 -> dumped addr1 still old value, addr3 = 0x9. A second DUMP_START mid-dump is ignored.
- Reset mid-dump: nRST=0 during SEND of addr 2 -> the next cycle VALID=0, BUSY=0, all registers read 0, no further dump words.

Source files
------------

// File: rtl/latch_regfile_dump.sv
// NREGS x XLEN register file with one write port, two combinational read ports
// and a valid/ready dump sequencer that streams every register out for readback.
module latch_regfile_dump #(
    parameter int  XLEN     = 4,
    parameter int  NREGS    = 4,
    parameter int  ZERO_REG = 0,
    parameter int  BYPASS   = 0,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            WE,
    input  logic [AW-1:0]   WADDR,
    input  logic [XLEN-1:0] WDATA,
    input  logic [AW-1:0]   RADDR1,
    output logic [XLEN-1:0] RDATA1,
    input  logic [AW-1:0]   RADDR2,
    output logic [XLEN-1:0] RDATA2,
    input  logic            DUMP_START,
    output logic            DUMP_BUSY,
    output logic            DUMP_VALID,
    input  logic            DUMP_READY,
    output logic [AW-1:0]   DUMP_ADDR,
    output logic [XLEN-1:0] DUMP_DATA
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } dump_state_t;

    logic [XLEN-1:0] regs_r [NREGS];
    dump_state_t     state_r;
    dump_state_t     next_s;
    logic [AW-1:0]   ptr_r;
    logic [AW-1:0]   addr_r;
    logic [XLEN-1:0] data_r;
    logic            busy_r;
    logic            valid_r;
    logic            busy_s;
    logic            valid_s;
    logic            wr_en_s;
    logic            xfer_s;
    logic            last_s;

    function automatic logic is_zero_addr(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == {AW{1'b0}});
    endfunction

    // A discarded zero-register write is never forwarded because the zero check wins.
    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]   raddr,
        input logic [XLEN-1:0] stored,
        input logic            wr_en,
        input logic [AW-1:0]   waddr,
        input logic [XLEN-1:0] wdata
    );
        logic [XLEN-1:0] word;
        if (is_zero_addr(raddr)) begin
            word = {XLEN{1'b0}};
        end else if ((BYPASS != 0) && wr_en && (waddr == raddr)) begin
            word = wdata;
        end else begin
            word = stored;
        end
        return word;
    endfunction

    assign wr_en_s = WE && !is_zero_addr(WADDR);
    assign xfer_s  = (state_r == SEND) && DUMP_READY;
    assign last_s  = (ptr_r == AW'(NREGS - 1));

    assign RDATA1 = read_port(RADDR1, regs_r[RADDR1], wr_en_s, WADDR, WDATA);
    assign RDATA2 = read_port(RADDR2, regs_r[RADDR2], wr_en_s, WADDR, WDATA);

    assign DUMP_BUSY  = busy_r;
    assign DUMP_VALID = valid_r;
    assign DUMP_ADDR  = addr_r;
    assign DUMP_DATA  = data_r;

    // Register storage: synchronous clear, then the single write port.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[WADDR] <= WDATA;
        end
    end

    // Dump FSM state register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Dump FSM next-state logic; a START pulse outside IDLE is ignored.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (DUMP_START) begin
                    next_s = LOAD;
                end else begin
                    next_s = IDLE;
                end
            end
            LOAD: next_s = SEND;
            SEND: begin
                if (xfer_s) begin
                    next_s = last_s ? IDLE : LOAD;
                end else begin
                    next_s = SEND;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // Dump FSM output decode, taken from the next state so the flags are registered.
    always_comb begin
        busy_s  = (next_s != IDLE);
        valid_s = (next_s == SEND);
    end

    // Dump datapath: word pointer, captured word and registered status flags.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ptr_r   <= {AW{1'b0}};
            addr_r  <= {AW{1'b0}};
            data_r  <= {XLEN{1'b0}};
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            busy_r  <= busy_s;
            valid_r <= valid_s;
            if ((state_r == IDLE) && DUMP_START) begin
                ptr_r <= {AW{1'b0}};
            end else if (xfer_s && !last_s) begin
                ptr_r <= ptr_r + AW'(1);
            end
            // Capture bypasses forwarding: only committed storage is dumped.
            if (state_r == LOAD) begin
                addr_r <= ptr_r;
                data_r <= is_zero_addr(ptr_r) ? {XLEN{1'b0}} : regs_r[ptr_r];
            end
        end
    end

endmodule

// File: tb/tb_latch_regfile_dump.sv
// Self-checking bench for latch_regfile_dump: table vectors, randomized traffic
// against an array model, and hand-written dump corner-case sequences.
module tb_latch_regfile_dump;
    localparam int NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst = 1'b0, we = 1'b0, dstart = 1'b0, dready = 1'b0;
    logic [1:0] waddr = 2'd0, raddr1 = 2'd0, raddr2 = 2'd0;
    logic [3:0] wdata = 4'd0;
    logic [3:0] rdata1, rdata2, ddata;
    logic [1:0] daddr;
    logic       dbusy, dvalid;

    logic       zwe = 1'b0;
    logic [2:0] zwaddr = 3'd0, zr1 = 3'd0, zr2 = 3'd0;
    logic [7:0] zwdata = 8'd0;
    logic [7:0] b_rd1, b_rd2, n_rd1, n_rd2, b_dd, n_dd;
    logic [2:0] b_da, n_da;
    logic       b_bz, b_vl, n_bz, n_vl;

    int checks = 0;
    int errors = 0;
    logic [3:0] model [NR];
    logic [3:0] expw  [NR];

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [3:0] wd;
        logic [1:0] r1;
        logic [1:0] r2;
        logic [3:0] e1;
        logic [3:0] e2;
    } vec_t;
    vec_t vecs [6];

    latch_regfile_dump dut (
        .CLK(clk), .nRST(nrst), .WE(we), .WADDR(waddr), .WDATA(wdata),
        .RADDR1(raddr1), .RDATA1(rdata1), .RADDR2(raddr2), .RDATA2(rdata2),
        .DUMP_START(dstart), .DUMP_BUSY(dbusy), .DUMP_VALID(dvalid),
        .DUMP_READY(dready), .DUMP_ADDR(daddr), .DUMP_DATA(ddata)
    );

    latch_regfile_dump #(.XLEN(8), .NREGS(8), .ZERO_REG(1), .BYPASS(1)) dut_byp (
        .CLK(clk), .nRST(nrst), .WE(zwe), .WADDR(zwaddr), .WDATA(zwdata),
        .RADDR1(zr1), .RDATA1(b_rd1), .RADDR2(zr2), .RDATA2(b_rd2),
        .DUMP_START(1'b0), .DUMP_BUSY(b_bz), .DUMP_VALID(b_vl),
        .DUMP_READY(1'b0), .DUMP_ADDR(b_da), .DUMP_DATA(b_dd)
    );

    latch_regfile_dump #(.XLEN(8), .NREGS(8), .ZERO_REG(1), .BYPASS(0)) dut_nob (
        .CLK(clk), .nRST(nrst), .WE(zwe), .WADDR(zwaddr), .WDATA(zwdata),
        .RADDR1(zr1), .RDATA1(n_rd1), .RADDR2(zr2), .RDATA2(n_rd2),
        .DUMP_START(1'b0), .DUMP_BUSY(n_bz), .DUMP_VALID(n_vl),
        .DUMP_READY(1'b0), .DUMP_ADDR(n_da), .DUMP_DATA(n_dd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        we = 1'b1; waddr = 2'(a); wdata = 4'(d);
        tick();
        we = 1'b0;
        model[a] = 4'(d);
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < NR; i++) begin
            raddr1 = 2'(i); raddr2 = 2'(NR - 1 - i);
            #1;
            chk(name, rdata1, 0);
            chk(name, rdata2, 0);
        end
    endtask

    task automatic start_dump();
        dstart = 1'b1; dready = 1'b1;
        tick();
        dstart = 1'b0;
    endtask

    // mode 0: READY high, 1: random READY, 2: five stall cycles on word 2
    task automatic collect(input int mode, input int first);
        int idx = first;
        int stall = 0;
        bit done = 1'b0;
        bit hold = 1'b0;
        logic [1:0] ha = 2'd0;
        logic [3:0] hd = 4'd0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (!dbusy) begin
                done = 1'b1;
            end else begin
                case (mode)
                    1: dready = 1'($urandom_range(0, 1));
                    2: begin
                        if (dvalid && daddr == 2'd2 && stall < 5) begin
                            dready = 1'b0; stall++;
                        end else begin
                            dready = 1'b1;
                        end
                    end
                    default: dready = 1'b1;
                endcase
                @(negedge clk);
                if (dvalid) begin
                    if (hold) begin
                        chk("hold_addr", daddr, ha);
                        chk("hold_data", ddata, hd);
                    end
                    if (dready) begin
                        chk("word_addr", daddr, idx);
                        chk("word_data", ddata, expw[idx]);
                        idx++;
                        hold = 1'b0;
                    end else begin
                        hold = 1'b1; ha = daddr; hd = ddata;
                    end
                end
                tick();
            end
        end
        chk("dump_done", done, 1);
        chk("word_count", idx, NR);
        if (mode == 2) chk("stall_cycles", stall, 5);
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd1, 4'hA, 2'd1, 2'd3, 4'hA, 4'h0};
        vecs[1] = '{1'b1, 2'd3, 4'h5, 2'd1, 2'd3, 4'hA, 4'h5};
        vecs[2] = '{1'b0, 2'd2, 4'hF, 2'd0, 2'd2, 4'h0, 4'h0};
        vecs[3] = '{1'b1, 2'd0, 4'h7, 2'd0, 2'd1, 4'h7, 4'hA};
        vecs[4] = '{1'b1, 2'd2, 4'hC, 2'd2, 2'd2, 4'hC, 4'hC};
        vecs[5] = '{1'b0, 2'd1, 4'h3, 2'd1, 2'd3, 4'hA, 4'h5};

        // reset also overrides a simultaneous write and START
        nrst = 1'b0; we = 1'b1; waddr = 2'd2; wdata = 4'hF; dstart = 1'b1;
        repeat (2) tick();
        nrst = 1'b1; we = 1'b0; dstart = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 4'd0;
        chk("rst_busy", dbusy, 0);
        chk("rst_valid", dvalid, 0);
        chk("rst_addr", daddr, 0);
        chk("rst_data", ddata, 0);
        check_all_zero("rst_regs");
        tick();
        chk("rst_no_start", dbusy, 0);

        for (int v = 0; v < 6; v++) begin
            we = vecs[v].we; waddr = vecs[v].wa; wdata = vecs[v].wd;
            tick();
            we = 1'b0;
            if (vecs[v].we) model[vecs[v].wa] = vecs[v].wd;
            raddr1 = vecs[v].r1; raddr2 = vecs[v].r2;
            #1;
            chk("vec_rd1", rdata1, vecs[v].e1);
            chk("vec_rd2", rdata2, vecs[v].e2);
        end

        // zero register and bypass on the 8x8 instances
        zwe = 1'b1; zwaddr = 3'd5; zwdata = 8'h11;
        tick();
        zwaddr = 3'd0; zwdata = 8'hFF; zr1 = 3'd0;
        #1;
        chk("zero_byp_same_cycle", b_rd1, 8'h00);
        tick();
        zwe = 1'b0;
        #1;
        chk("zero_byp_after", b_rd1, 8'h00);
        chk("zero_nob_after", n_rd1, 8'h00);
        zwe = 1'b1; zwaddr = 3'd5; zwdata = 8'h3C; zr2 = 3'd5;
        #1;
        chk("byp_rd2_fwd", b_rd2, 8'h3C);
        chk("nob_rd2_old", n_rd2, 8'h11);
        tick();
        zwe = 1'b0;
        #1;
        chk("nob_rd2_new", n_rd2, 8'h3C);
        chk("byp_rd2_new", b_rd2, 8'h3C);
        zwe = 1'b1; zwaddr = 3'd4; zwdata = 8'h77; zr1 = 3'd4;
        #1;
        chk("byp_rd1_fwd", b_rd1, 8'h77);
        chk("nob_rd1_old", n_rd1, 8'h00);
        chk("byp_rd2_other", b_rd2, 8'h3C);
        tick();
        zwe = 1'b0;

        // randomized write/read traffic against the array model
        for (int it = 0; it < 40; it++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 2'($urandom_range(0, NR - 1));
            wdata = 4'($urandom_range(0, 15));
            raddr1 = 2'($urandom_range(0, NR - 1));
            raddr2 = 2'($urandom_range(0, NR - 1));
            #1;
            chk("rand_rd1_pre", rdata1, model[raddr1]);
            chk("rand_rd2_pre", rdata2, model[raddr2]);
            tick();
            if (we) model[waddr] = wdata;
            we = 1'b0;
            #1;
            chk("rand_rd1_post", rdata1, model[raddr1]);
            chk("rand_rd2_post", rdata2, model[raddr2]);
        end

        // full dump with READY high: a word on every other cycle, BUSY low after 8
        for (int i = 0; i < NR; i++) wr(i, i + 1);
        start_dump();
        for (int k = 1; k <= 2 * NR; k++) begin
            tick();
            chk("full_busy", dbusy, (k < 2 * NR) ? 1 : 0);
            chk("full_valid", dvalid, ((k % 2 == 1) && k < 2 * NR) ? 1 : 0);
            if ((k % 2 == 1) && k < 2 * NR) begin
                chk("full_addr", daddr, (k - 1) / 2);
                chk("full_data", ddata, model[(k - 1) / 2]);
            end
        end

        // backpressure on word 2
        expw = model;
        start_dump();
        collect(2, 0);

        // random READY and random contents
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 6; j++) wr($urandom_range(0, NR - 1), $urandom_range(0, 15));
            expw = model;
            start_dump();
            collect(1, 0);
        end

        // writes during a dump, plus an ignored second START
        for (int i = 0; i < NR; i++) wr(i, i + 1);
        start_dump();
        tick();
        tick();
        dready = 1'b0;
        tick();
        chk("wdd_valid_at1", dvalid, 1);
        chk("wdd_addr_at1", daddr, 1);
        we = 1'b1; waddr = 2'd1; wdata = 4'hF; dstart = 1'b1;
        tick();
        waddr = 2'd3; wdata = 4'h9; dstart = 1'b0;
        tick();
        we = 1'b0;
        expw[0] = 4'h1; expw[1] = 4'h2; expw[2] = 4'h3; expw[3] = 4'h9;
        model[1] = 4'hF; model[3] = 4'h9;
        collect(0, 1);
        raddr1 = 2'd1; raddr2 = 2'd3;
        #1;
        chk("wdd_reg1", rdata1, model[1]);
        chk("wdd_reg3", rdata2, model[3]);

        // reset in the middle of a dump
        start_dump();
        for (int c = 0; c < 20 && !(dvalid && daddr == 2'd2); c++) tick();
        chk("rmd_reached_addr2", (dvalid && daddr == 2'd2) ? 1 : 0, 1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = 4'd0;
        chk("rmd_valid", dvalid, 0);
        chk("rmd_busy", dbusy, 0);
        chk("rmd_data", ddata, 0);
        check_all_zero("rmd_regs");
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rmd_no_words", {30'd0, dbusy, dvalid}, 0);
        end
        dready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
